// File: rtl/uart_rx_pkt_ctrl.sv
// Frames the UART receiver byte stream (SOF, LEN, payload, CHK) into packets and streams the
// validated payload out on valid/ready. Define UART_RX_PKT_STATS_EN to add packet counters.
module uart_rx_pkt_ctrl #(
  parameter int unsigned MAX_LEN       = 16,
  parameter logic [7:0]  SOF           = 8'hA5,
  parameter int unsigned TIMEOUT_TICKS = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_done_tick,
  input  logic [7:0]  rx_data,
  input  logic        s_tick,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy,
  output logic        err_chk,
  output logic        err_len,
  output logic        err_timeout,
`ifdef UART_RX_PKT_STATS_EN
  output logic        overrun,
  output logic [15:0] pkt_ok_cnt,
  output logic [15:0] pkt_err_cnt
`else
  output logic        overrun
`endif
);

  localparam int unsigned CW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [7:0]    MaxLen8  = 8'(MAX_LEN);
  localparam logic [TW-1:0] TickLast = TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {StIdle, StLen, StPayload, StChk, StSend} state_e;

  state_e          state_q;
  logic [CW-1:0]   len_q, idx_q, rd_q;
  logic [CW-1:0]   idx_nxt, rd_nxt;
  logic [7:0]      sum_q, sum_nxt;
  logic [TW-1:0]   tick_q;
  logic            in_frame, timeout_hit;
  logic [7:0]      pkt_buf [MAX_LEN];

  assign idx_nxt  = idx_q + 1'b1;
  assign rd_nxt   = rd_q + 1'b1;
  assign sum_nxt  = sum_q + rx_data;
  assign in_frame = (state_q == StLen) || (state_q == StPayload) || (state_q == StChk);
  // A byte arriving on the terminal tick wins over the timeout.
  assign timeout_hit = s_tick && !rx_done_tick && (tick_q == TickLast);

  always_ff @(posedge clk) begin
    if (state_q == StPayload && rx_done_tick) begin
      pkt_buf[idx_q[AW-1:0]] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      idx_q       <= '0;
      rd_q        <= '0;
      sum_q       <= '0;
      tick_q      <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;

      // Held at zero outside a frame, so every entry into LEN starts from a cleared count.
      if (rx_done_tick || !in_frame) begin
        tick_q <= '0;
      end else if (s_tick) begin
        tick_q <= tick_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (rx_done_tick && rx_data == SOF) begin
            state_q <= StLen;
            busy    <= 1'b1;
          end
        end

        StLen: begin
          if (rx_done_tick) begin
            if (rx_data == 8'd0 || rx_data > MaxLen8) begin
              err_len <= 1'b1;
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              len_q   <= rx_data[CW-1:0];
              sum_q   <= rx_data;
              idx_q   <= '0;
              state_q <= StPayload;
            end
          end else if (timeout_hit) begin
            err_timeout <= 1'b1;
            state_q     <= StIdle;
            busy        <= 1'b0;
          end
        end

        StPayload: begin
          if (rx_done_tick) begin
            sum_q <= sum_nxt;
            idx_q <= idx_nxt;
            if (idx_nxt == len_q) begin
              state_q <= StChk;
            end
          end else if (timeout_hit) begin
            err_timeout <= 1'b1;
            state_q     <= StIdle;
            busy        <= 1'b0;
          end
        end

        StChk: begin
          if (rx_done_tick) begin
            if (sum_nxt == 8'd0) begin
              state_q   <= StSend;
              rd_q      <= '0;
              out_valid <= 1'b1;
              out_data  <= pkt_buf[0];
              out_last  <= (len_q == CW'(1));
            end else begin
              err_chk <= 1'b1;
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end else if (timeout_hit) begin
            err_timeout <= 1'b1;
            state_q     <= StIdle;
            busy        <= 1'b0;
          end
        end

        StSend: begin
          if (rx_done_tick) begin
            overrun <= 1'b1;
          end
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state_q   <= StIdle;
              busy      <= 1'b0;
            end else begin
              rd_q     <= rd_nxt;
              out_data <= pkt_buf[rd_nxt[AW-1:0]];
              out_last <= (rd_nxt == len_q - 1'b1);
            end
          end
        end

        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_RX_PKT_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_ok_cnt  <= '0;
      pkt_err_cnt <= '0;
    end else begin
      if (out_valid && out_ready && out_last) begin
        pkt_ok_cnt <= pkt_ok_cnt + 16'd1;
      end
      if (err_chk || err_len || err_timeout) begin
        pkt_err_cnt <= pkt_err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: framing, errors, timeout, backpressure and reset.
module tb_uart_rx_pkt_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       s_tick = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid, out_last, busy, err_chk, err_len, err_timeout, overrun;
  logic [7:0] out_data;
`ifdef UART_RX_PKT_STATS_EN
  logic [15:0] pkt_ok_cnt, pkt_err_cnt;
`endif

  int nvec = 0;
  int nerr = 0;
  int n_chk, n_len, n_to, n_ovr, n_valid;

  uart_rx_pkt_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .s_tick       (s_tick),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .err_chk      (err_chk),
    .err_len      (err_len),
    .err_timeout  (err_timeout),
`ifdef UART_RX_PKT_STATS_EN
    .overrun      (overrun),
    .pkt_ok_cnt   (pkt_ok_cnt),
    .pkt_err_cnt  (pkt_err_cnt)
`else
    .overrun      (overrun)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_chk) n_chk++;
    if (err_len) n_len++;
    if (err_timeout) n_to++;
    if (overrun) n_ovr++;
    if (out_valid) n_valid++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    n_chk = 0; n_len = 0; n_to = 0; n_ovr = 0; n_valid = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_done_tick = 1'b1;
    rx_data      = b;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    if ({out_valid, out_last, busy, err_chk, err_len, err_timeout, overrun} !== 7'b0) begin
      $display("FAIL reset_flags: got %b want 0000000",
               {out_valid, out_last, busy, err_chk, err_len, err_timeout, overrun});
      nerr++;
    end
    nvec++;
    if (out_data !== 8'h00) begin
      $display("FAIL reset_data: got %h want 00", out_data); nerr++;
    end
    nvec++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_good_frame();
    clear_mon();
    out_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h97);
    if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 8'h11}) begin
      $display("FAIL good_b0: got v%b l%b %h want v1 l0 11", out_valid, out_last, out_data);
      nerr++;
    end
    nvec++;
    @(posedge clk); #1;
    if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 8'h22}) begin
      $display("FAIL good_b1: got v%b l%b %h want v1 l0 22", out_valid, out_last, out_data);
      nerr++;
    end
    nvec++;
    @(posedge clk); #1;
    if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 8'h33}) begin
      $display("FAIL good_b2: got v%b l%b %h want v1 l1 33", out_valid, out_last, out_data);
      nerr++;
    end
    nvec++;
    @(posedge clk); #1;
    if ({out_valid, busy} !== 2'b00) begin
      $display("FAIL good_end: got valid/busy %b want 00", {out_valid, busy}); nerr++;
    end
    nvec++;
    if (n_chk + n_len + n_to !== 0) begin
      $display("FAIL good_noerr: got %0d error pulses want 0", n_chk + n_len + n_to); nerr++;
    end
    nvec++;
  endtask

  task automatic test_bad_chk();
    clear_mon();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
    send_byte(8'h20); send_byte(8'h00);
    if ({err_chk, busy} !== 2'b10) begin
      $display("FAIL badchk_pulse: got err_chk/busy %b want 10", {err_chk, busy}); nerr++;
    end
    nvec++;
    @(posedge clk); #1;
    if (n_chk !== 1 || n_valid !== 0) begin
      $display("FAIL badchk_count: got chk %0d valid %0d want 1 0", n_chk, n_valid); nerr++;
    end
    nvec++;
  endtask

  task automatic test_len_err();
    clear_mon();
    send_byte(8'hA5); send_byte(8'h00);
    if (err_len !== 1'b1) begin
      $display("FAIL len_zero: got err_len %b want 1", err_len); nerr++;
    end
    nvec++;
    send_byte(8'hA5); send_byte(8'h11);
    if (err_len !== 1'b1) begin
      $display("FAIL len_big: got err_len %b want 1", err_len); nerr++;
    end
    nvec++;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
    if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 8'h7F}) begin
      $display("FAIL len_recover: got v%b l%b %h want v1 l1 7f", out_valid, out_last, out_data);
      nerr++;
    end
    nvec++;
    @(posedge clk); #1;
    if (out_valid !== 1'b0 || n_len !== 2 || n_chk + n_to !== 0) begin
      $display("FAIL len_end: got valid %b len %0d other %0d want 0 2 0",
               out_valid, n_len, n_chk + n_to);
      nerr++;
    end
    nvec++;
  endtask

  task automatic test_timeout();
    clear_mon();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
    s_tick = 1'b1;
    repeat (2047) @(posedge clk);
    #1;
    if (busy !== 1'b1 || n_to !== 0) begin
      $display("FAIL to_early: got busy %b timeouts %0d want 1 0", busy, n_to); nerr++;
    end
    nvec++;
    @(posedge clk); #1;
    s_tick = 1'b0;
    if ({err_timeout, busy} !== 2'b10) begin
      $display("FAIL to_fire: got err_timeout/busy %b want 10", {err_timeout, busy}); nerr++;
    end
    nvec++;
    @(posedge clk); #1;
    if (n_to !== 1) begin
      $display("FAIL to_count: got %0d want 1", n_to); nerr++;
    end
    nvec++;

    clear_mon();
    out_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
    s_tick = 1'b1;
    repeat (2047) @(posedge clk);
    #1;
    rx_done_tick = 1'b1;
    rx_data      = 8'h20;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    s_tick       = 1'b0;
    if ({err_timeout, busy} !== 2'b01) begin
      $display("FAIL to_race: got err_timeout/busy %b want 01", {err_timeout, busy}); nerr++;
    end
    nvec++;
    send_byte(8'hCE);
    if ({out_valid, out_data} !== {1'b1, 8'h10}) begin
      $display("FAIL to_race_b0: got v%b %h want v1 10", out_valid, out_data); nerr++;
    end
    nvec++;
    @(posedge clk); #1;
    if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 8'h20}) begin
      $display("FAIL to_race_b1: got v%b l%b %h want v1 l1 20", out_valid, out_last, out_data);
      nerr++;
    end
    nvec++;
    @(posedge clk); #1;
    if (n_to !== 0 || busy !== 1'b0) begin
      $display("FAIL to_race_end: got timeouts %0d busy %b want 0 0", n_to, busy); nerr++;
    end
    nvec++;
  endtask

  task automatic test_backpressure();
    clear_mon();
    out_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA); send_byte(8'h55); send_byte(8'hFF);
    for (int i = 0; i < 10; i++) begin
      if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 8'hAA}) begin
        $display("FAIL bp_hold[%0d]: got v%b l%b %h want v1 l0 aa",
                 i, out_valid, out_last, out_data);
        nerr++;
      end
      nvec++;
      @(posedge clk); #1;
    end
    send_byte(8'hA5);
    if ({overrun, out_data} !== {1'b1, 8'hAA}) begin
      $display("FAIL bp_overrun: got ovr %b %h want 1 aa", overrun, out_data); nerr++;
    end
    nvec++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 8'h55}) begin
      $display("FAIL bp_b1: got v%b l%b %h want v1 l1 55", out_valid, out_last, out_data);
      nerr++;
    end
    nvec++;
    @(posedge clk); #1;
    if ({out_valid, busy} !== 2'b00 || n_ovr !== 1 || n_chk + n_len + n_to !== 0) begin
      $display("FAIL bp_end: got v/b %b ovr %0d err %0d want 00 1 0",
               {out_valid, busy}, n_ovr, n_chk + n_len + n_to);
      nerr++;
    end
    nvec++;
  endtask

  task automatic test_reset_mid();
    clear_mon();
    out_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01);
    if (busy !== 1'b1) begin
      $display("FAIL rst_mid_busy: got %b want 1", busy); nerr++;
    end
    nvec++;
    #3;
    reset = 1'b0;
    #1;
    if ({out_valid, out_last, busy, err_chk, err_len, err_timeout, overrun, out_data} !== 15'b0)
    begin
      $display("FAIL rst_mid_async: got %b want all 0",
               {out_valid, out_last, busy, err_chk, err_len, err_timeout, overrun, out_data});
      nerr++;
    end
    nvec++;
    @(negedge clk);
    reset = 1'b1;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h42); send_byte(8'hBD);
    if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 8'h42}) begin
      $display("FAIL rst_fresh: got v%b l%b %h want v1 l1 42", out_valid, out_last, out_data);
      nerr++;
    end
    nvec++;
    @(posedge clk); #1;
    if (out_valid !== 1'b0 || n_chk + n_len + n_to !== 0) begin
      $display("FAIL rst_fresh_end: got valid %b errs %0d want 0 0",
               out_valid, n_chk + n_len + n_to);
      nerr++;
    end
    nvec++;
`ifdef UART_RX_PKT_STATS_EN
    @(posedge clk); #1;
    if (pkt_ok_cnt !== 16'd1 || pkt_err_cnt !== 16'd0) begin
      $display("FAIL stats: got ok %0d err %0d want 1 0", pkt_ok_cnt, pkt_err_cnt); nerr++;
    end
    nvec++;
`endif
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_len_err();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
